stim_misr_harness: RTL and testbench

Synthesizable, parametrised stimulus-and-signature harness for fuzzed `top` designs. It replaces the fixed-vector, print-per-clock bench with on-chip generation and checking. An LFSR generates pseudo-random input vectors of arbitrary width, holds each for a programmable number of clocks, and compacts the DUT response into a MISR signature. Each run is therefore summarised by a single word that can be compared across synthesis tools.

---
 rtl/stim_misr_harness.sv | 226 ++++++++++++++++++++++
 tb/tb_stim_misr_harness.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_misr_harness.sv
// stim_misr_harness
//
// On-chip stimulus generator and response compactor for fuzzed designs.
// A 64-bit Galois LFSR produces the input vectors. Each vector is replicated to STIM_W bits and
// held for HOLD clocks. The first vector of a run is all-zero. The DUT response is folded to
// SIG_W bits and compacted into a MISR on the last clock of every hold window. That sample strobe
// is delayed by LAT clocks to line up with the DUT's pipeline. A whole run ends up as one
// signature word.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle run request, accepted only when idle or done
//   seed       LFSR seed, sampled when start is accepted (0 is replaced by 1)
//   stim       registered stimulus to the DUT
//   resp       DUT response
//   busy       run in progress
//   done       run finished; held until the next accepted start
//   signature  MISR value, frozen while done is high
//   vec_idx    index of the vector being driven (0 = zero vector)

module stim_misr_harness #(
  parameter int unsigned      STIM_W  = 84,
  parameter int unsigned      RESP_W  = 119,
  parameter int unsigned      SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(32'h04C11DB7),
  parameter int unsigned      NUM_VEC = 21,
  parameter int unsigned      HOLD    = 2,
  parameter int unsigned      LAT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       seed,
  output logic [STIM_W-1:0] stim,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       vec_idx
);

  // Number of 64-bit LFSR copies needed to cover the stimulus width.
  localparam int unsigned NREP   = (STIM_W + 63) / 64;
  // Number of SIG_W-bit chunks the response is split into for folding.
  localparam int unsigned NCHUNK = (RESP_W + SIG_W - 1) / SIG_W;
  // The strobe delay line needs at least one bit to stay legal when LAT is 0.
  localparam int unsigned SR_W   = (LAT == 0) ? 1 : LAT;

  localparam logic [7:0]  HoldLast  = 8'(HOLD - 1);
  localparam logic [7:0]  LatLast   = 8'((LAT == 0) ? 0 : LAT - 1);
  localparam logic [15:0] NumVecIdx = 16'(NUM_VEC);
  localparam logic [63:0] LfsrTaps  = 64'hD800000000000000;

  typedef enum logic [2:0] {
    StIdle,
    StZero,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         lfsr_q, lfsr_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [15:0]         vec_q, vec_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;

  logic                win_end;
  logic                strobe;
  logic                strobe_dly;
  logic [63:0]         lfsr_step;
  logic [STIM_W-1:0]   stim_step;
  logic [NCHUNK*SIG_W-1:0] resp_pad;
  logic [SIG_W-1:0]    fold;
  logic [SIG_W-1:0]    misr_next;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------

  // Galois LFSR, right shift, taps folded in from bit 0.
  assign lfsr_step = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? LfsrTaps : 64'h0);

  // Stimulus bit i takes lfsr bit (i mod 64). Replicate, then truncate to the stimulus width.
  assign stim_step = STIM_W'({NREP{lfsr_step}});

  // Fold the response into SIG_W bits. The top chunk is zero-padded.
  always_comb begin
    resp_pad               = '0;
    resp_pad[RESP_W-1:0]   = resp;
    fold                   = '0;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      fold = fold ^ resp_pad[c*SIG_W +: SIG_W];
    end
  end

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;

  // The last clock of each hold window. The zero window counts too.
  assign win_end = (cnt_q == HoldLast);
  assign strobe  = ((state_q == StZero) || (state_q == StRun)) && win_end;

  // With LAT = 0 the strobe is used as-is. Otherwise it comes from the tail of the delay line.
  assign strobe_dly = (LAT == 0) ? strobe : sr_q[SR_W-1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= 64'h1;
      stim_q  <= '0;
      sig_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q << 1;
    sr_d[0] = strobe;

    // Delayed strobes only land while a run is active, so no start can race them.
    if (strobe_dly) begin
      sig_d = misr_next;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StZero;
          lfsr_d  = (seed == 64'h0) ? 64'h1 : seed;
          stim_d  = '0;
          sig_d   = '0;
          vec_d   = '0;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end

      StZero: begin
        if (win_end) begin
          state_d = StRun;
          lfsr_d  = lfsr_step;
          stim_d  = stim_step;
          vec_d   = 16'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRun: begin
        if (win_end) begin
          cnt_d = '0;
          if (vec_q < NumVecIdx) begin
            lfsr_d = lfsr_step;
            stim_d = stim_step;
            vec_d  = vec_q + 16'd1;
          end else begin
            // Without latency there is nothing left to wait for, so DRAIN is skipped.
            state_d = (LAT == 0) ? StDone : StDrain;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDrain: begin
        // The final delayed strobe lands on the last DRAIN clock.
        if (cnt_q == LatLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StZero, StRun, StDrain: busy = 1'b1;
      StDone:                 done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign stim      = stim_q;
  assign signature = sig_q;
  assign vec_idx   = vec_q;

endmodule

// File: tb/tb_stim_misr_harness.sv
// Directed bench for stim_misr_harness.
// Four instances cover the parameter sets that the scenarios need:
//   u_dflt  default sizes with LAT=3 (reset, length, latency)
//   u_lfsr  STIM_W=64, HOLD=1, NUM_VEC=3 (LFSR sequence, zero seed, held start)
//   u_misr  RESP_W=32, NUM_VEC=1 (MISR arithmetic, stimulus replication)
//   u_fold  RESP_W=119, NUM_VEC=1, LAT=2 (folding and delayed sampling)

module tb_stim_misr_harness;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u_dflt
  logic         d_start = 1'b0;
  logic [63:0]  d_seed  = '0;
  logic [83:0]  d_stim;
  logic [118:0] d_resp  = '0;
  logic         d_busy, d_done;
  logic [31:0]  d_sig;
  logic [15:0]  d_vec;

  // u_lfsr
  logic         l_start = 1'b0;
  logic [63:0]  l_seed  = '0;
  logic [63:0]  l_stim;
  logic [31:0]  l_resp  = '0;
  logic         l_busy, l_done;
  logic [31:0]  l_sig;
  logic [15:0]  l_vec;

  // u_misr
  logic         m_start = 1'b0;
  logic [63:0]  m_seed  = '0;
  logic [83:0]  m_stim;
  logic [31:0]  m_resp  = '0;
  logic         m_busy, m_done;
  logic [31:0]  m_sig;
  logic [15:0]  m_vec;

  // u_fold
  logic         f_start = 1'b0;
  logic [63:0]  f_seed  = '0;
  logic [83:0]  f_stim;
  logic [118:0] f_resp  = '0;
  logic         f_busy, f_done;
  logic [31:0]  f_sig;
  logic [15:0]  f_vec;

  stim_misr_harness #(.LAT(3)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start(d_start), .seed(d_seed), .stim(d_stim), .resp(d_resp),
    .busy(d_busy), .done(d_done), .signature(d_sig), .vec_idx(d_vec)
  );

  stim_misr_harness #(.STIM_W(64), .RESP_W(32), .NUM_VEC(3), .HOLD(1), .LAT(0)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .start(l_start), .seed(l_seed), .stim(l_stim), .resp(l_resp),
    .busy(l_busy), .done(l_done), .signature(l_sig), .vec_idx(l_vec)
  );

  stim_misr_harness #(.RESP_W(32), .NUM_VEC(1), .LAT(0)) u_misr (
    .clk(clk), .rst_n(rst_n), .start(m_start), .seed(m_seed), .stim(m_stim), .resp(m_resp),
    .busy(m_busy), .done(m_done), .signature(m_sig), .vec_idx(m_vec)
  );

  stim_misr_harness #(.NUM_VEC(1), .LAT(2)) u_fold (
    .clk(clk), .rst_n(rst_n), .start(f_start), .seed(f_seed), .stim(f_stim), .resp(f_resp),
    .busy(f_busy), .done(f_done), .signature(f_sig), .vec_idx(f_vec)
  );

  // Signature after n strobes with a constant folded response f.
  function automatic logic [31:0] misr_const(input int n, input logic [31:0] f);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    end
    return s;
  endfunction

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", d_busy); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", d_done); end
    checks++; if (d_stim !== 84'h0) begin errors++; $display("FAIL reset_stim: got %h want 0", d_stim); end
    checks++; if (d_sig !== 32'h0) begin errors++; $display("FAIL reset_sig: got %h want 0", d_sig); end
    checks++; if (d_vec !== 16'h0) begin errors++; $display("FAIL reset_vec: got %0d want 0", d_vec); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lfsr;
    logic [63:0] exp_stim [4];
    exp_stim[0] = 64'h0;
    exp_stim[1] = 64'hD800000000000000;
    exp_stim[2] = 64'h6C00000000000000;
    exp_stim[3] = 64'h3600000000000000;
    l_seed = 64'h1;
    l_resp = '0;
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (l_stim !== exp_stim[k]) begin
        errors++; $display("FAIL lfsr_stim[%0d]: got %h want %h", k, l_stim, exp_stim[k]);
      end
      checks++;
      if (l_vec !== 16'(k) || l_busy !== 1'b1) begin
        errors++; $display("FAIL lfsr_idx[%0d]: got vec=%0d busy=%b want vec=%0d busy=1",
                           k, l_vec, l_busy, k);
      end
      @(negedge clk);
    end
    checks++;
    if (l_done !== 1'b1 || l_busy !== 1'b0) begin
      errors++; $display("FAIL lfsr_done: got done=%b busy=%b want 1/0", l_done, l_busy);
    end
    checks++; if (l_sig !== 32'h0) begin errors++; $display("FAIL lfsr_sig: got %h want 0", l_sig); end
    checks++;
    if (l_stim !== 64'h3600000000000000) begin
      errors++; $display("FAIL lfsr_hold_last: got %h want 3600000000000000", l_stim);
    end
  endtask

  // Seed 0 must behave like seed 1. start stays high throughout to check it is ignored
  // mid-run and retriggers one clock after done.
  task automatic test_zero_seed;
    int n;
    logic [63:0] exp_stim [4];
    exp_stim[0] = 64'h0;
    exp_stim[1] = 64'hD800000000000000;
    exp_stim[2] = 64'h6C00000000000000;
    exp_stim[3] = 64'h3600000000000000;
    l_seed = 64'h0;
    l_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (l_stim !== exp_stim[k] || l_vec !== 16'(k)) begin
        errors++; $display("FAIL zseed_stim[%0d]: got %h/%0d want %h/%0d",
                           k, l_stim, l_vec, exp_stim[k], k);
      end
      @(negedge clk);
    end
    checks++;
    if (l_done !== 1'b1 || l_busy !== 1'b0) begin
      errors++; $display("FAIL zseed_done: got done=%b busy=%b want 1/0", l_done, l_busy);
    end
    @(negedge clk);
    checks++;
    if (l_busy !== 1'b1 || l_done !== 1'b0 || l_vec !== 16'h0 || l_stim !== 64'h0) begin
      errors++; $display("FAIL retrigger: got busy=%b done=%b vec=%0d stim=%h want 1/0/0/0",
                         l_busy, l_done, l_vec, l_stim);
    end
    l_start = 1'b0;
    n = 0;
    while (l_done !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++; if (l_done !== 1'b1) begin errors++; $display("FAIL retrig_finish: got done=%b want 1", l_done); end
  endtask

  task automatic test_misr;
    int n;
    m_seed = 64'h2;
    m_resp = 32'hFFFFFFFF;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    @(negedge clk);
    checks++; if (m_stim !== 84'h0) begin errors++; $display("FAIL misr_zero_stim: got %h want 0", m_stim); end
    @(negedge clk);
    checks++;
    if (m_sig !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL misr_first: got %h want ffffffff", m_sig);
    end
    checks++;
    if (m_stim !== 84'h00001_0000000000000001 || m_vec !== 16'd1) begin
      errors++; $display("FAIL misr_repl_stim: got %h/%0d want 00001_0000000000000001/1",
                         m_stim, m_vec);
    end
    @(negedge clk);
    checks++;
    if (m_stim !== 84'h00001_0000000000000001) begin
      errors++; $display("FAIL misr_stim_held: got %h want 00001_0000000000000001", m_stim);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0) begin
      errors++; $display("FAIL misr_done: got done=%b busy=%b want 1/0", m_done, m_busy);
    end
    checks++;
    if (m_sig !== 32'h04C11DB6) begin
      errors++; $display("FAIL misr_sig: got %h want 04c11db6", m_sig);
    end
    // A new start must clear the previous signature.
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    checks++;
    if (m_sig !== 32'h0 || m_done !== 1'b0) begin
      errors++; $display("FAIL misr_restart: got sig=%h done=%b want 0/0", m_sig, m_done);
    end
    n = 0;
    while (m_done !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (m_sig !== 32'h04C11DB6) begin
      errors++; $display("FAIL misr_rerun: got %h want 04c11db6", m_sig);
    end
  endtask

  // Response is valid only on the clocks where the LAT=2 delayed strobes land (busy cycles 4, 6).
  task automatic test_fold;
    logic [118:0] top_bit;
    int nbusy;
    top_bit = '0;
    top_bit[118] = 1'b1;
    f_seed = 64'h5;
    f_resp = '0;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    nbusy = 0;
    for (int c = 1; c <= 6; c++) begin
      f_resp = (c == 4 || c == 6) ? top_bit : '0;
      if (f_busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    f_resp = '0;
    checks++; if (nbusy !== 6) begin errors++; $display("FAIL fold_busy_len: got %0d want 6", nbusy); end
    checks++;
    if (f_done !== 1'b1 || f_busy !== 1'b0) begin
      errors++; $display("FAIL fold_done: got done=%b busy=%b want 1/0", f_done, f_busy);
    end
    checks++;
    if (f_sig !== 32'h00C00000) begin
      errors++; $display("FAIL fold_sig: got %h want 00c00000", f_sig);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    d_seed = 64'h0123456789ABCDEF;
    d_resp = 119'h1;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    n = 0;
    while (d_vec !== 16'd5 && n < 40) begin n++; @(negedge clk); end
    checks++; if (d_vec !== 16'd5) begin errors++; $display("FAIL midrun_reach: got %0d want 5", d_vec); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_busy !== 1'b0 || d_done !== 1'b0 || d_stim !== 84'h0 || d_sig !== 32'h0 ||
        d_vec !== 16'h0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b done=%b stim=%h sig=%h vec=%0d want all 0",
                         d_busy, d_done, d_stim, d_sig, d_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL midrun_no_done: got %b want 0", d_done); end
  endtask

  // Full default run with LAT=3: 22*2+3 = 47 busy clocks, 22 strobes of fold=1.
  // Two stray start pulses during the run must change nothing.
  task automatic test_latency;
    int n;
    int exp_vec;
    int vec_bad;
    int overlap;
    logic [31:0] exp_sig;
    exp_sig = misr_const(22, 32'h1);
    d_seed = 64'h000000000000CAFE;
    d_resp = 119'h1;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    n = 0;
    vec_bad = 0;
    overlap = 0;
    while (d_busy === 1'b1 && n < 100) begin
      n++;
      exp_vec = ((n - 1) / 2 > 21) ? 21 : (n - 1) / 2;
      if (d_vec !== 16'(exp_vec)) vec_bad++;
      if (d_done !== 1'b0) overlap++;
      d_start = (n == 10 || n == 30);
      @(negedge clk);
    end
    d_start = 1'b0;
    checks++; if (n !== 47) begin errors++; $display("FAIL busy_len: got %0d want 47", n); end
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL vec_windows: got %0d bad want 0", vec_bad); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL busy_done_overlap: got %0d want 0", overlap); end
    checks++;
    if (d_done !== 1'b1 || d_vec !== 16'd21) begin
      errors++; $display("FAIL len_done: got done=%b vec=%0d want 1/21", d_done, d_vec);
    end
    checks++;
    if (d_sig !== exp_sig) begin
      errors++; $display("FAIL len_sig: got %h want %h", d_sig, exp_sig);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d_sig !== exp_sig || d_done !== 1'b1) begin
      errors++; $display("FAIL done_frozen: got sig=%h done=%b want %h/1", d_sig, d_done, exp_sig);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_zero_seed();
    test_misr();
    test_fold();
    test_reset_mid_run();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
